// File: rtl/mdu_seq.sv
// -----------------------------------------------------------------------------
// mdu_seq : sequenced multiply/divide unit for the E stage of the MIPS pipeline.
//
// Executes mult/multu/div/divu over a fixed number of cycles, owns HI/LO,
// serves mfhi/mflo (combinational read) and mthi/mtlo (single-cycle write),
// and reports Busy so the hazard unit can stall dependent MDU instructions.
//
// The result is computed combinationally from A/B at the accepting edge and
// parked in pending registers; the counter only models the latency, and the
// pending values are committed to HI/LO when the counter expires.
//
// Ports
//   clk    in   1      rising-edge clock
//   reset  in   1      synchronous, active-high
//   Start  in   1      E-stage instruction is mult/multu/div/divu
//   MDUOp  in   4      0 none, 1 mult, 2 multu, 3 div, 4 divu,
//                      5 mfhi, 6 mflo, 7 mthi, 8 mtlo, others none
//   Req    in   1      exception/interrupt flush; blocks new ops and mthi/mtlo
//   A      in   WIDTH  forwarded rs
//   B      in   WIDTH  forwarded rt
//   Busy   out  1      operation in flight (registered)
//   HI     out  WIDTH  HI register
//   LO     out  WIDTH  LO register
//   Out    out  WIDTH  HI for mfhi, LO for mflo, else 0 (combinational)
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | no op in flight; accepts Start ops and mthi/mtlo
// RUN     | op in flight; counter holds cycles remaining, HI/LO still stale
// -----------------------------------------------------------------------------
module mdu_seq #(
    parameter int WIDTH      = 32,
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             Start,
    input  logic [3:0]       MDUOp,
    input  logic             Req,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             Busy,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO,
    output logic [WIDTH-1:0] Out
);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5;
    localparam logic [3:0] OP_MFLO  = 4'd6;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_RUN  = 1'b1;

    localparam int MAXC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    localparam logic [CW-1:0] CNT_MUL  = CW'(MUL_CYCLES);
    localparam logic [CW-1:0] CNT_DIV  = CW'(DIV_CYCLES);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_ZERO = '0;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic             r_state;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_hi_pend;
    logic [WIDTH-1:0] r_lo_pend;
    logic             r_pend_wr;

    // ------------------------------------------------------------------
    // Command decode
    // ------------------------------------------------------------------
    logic w_idle;
    logic w_is_mul;
    logic w_is_div;
    logic w_accept;
    logic w_mthi;
    logic w_mtlo;

    assign w_idle   = (r_state == ST_IDLE);
    assign w_is_mul = (MDUOp == OP_MULT) || (MDUOp == OP_MULTU);
    assign w_is_div = (MDUOp == OP_DIV)  || (MDUOp == OP_DIVU);
    assign w_accept = w_idle && Start && !Req && (w_is_mul || w_is_div);
    // mthi/mtlo are not gated by Start; MDUOp alone identifies them.
    assign w_mthi   = w_idle && !Req && (MDUOp == OP_MTHI);
    assign w_mtlo   = w_idle && !Req && (MDUOp == OP_MTLO);

    // ------------------------------------------------------------------
    // Multiply: extend to 2*WIDTH so one unsigned multiplier covers both
    // signednesses; the low 2*WIDTH bits of the extended product are exact.
    // ------------------------------------------------------------------
    logic [2*WIDTH-1:0] w_a_ext;
    logic [2*WIDTH-1:0] w_b_ext;
    logic [2*WIDTH-1:0] w_prod;

    assign w_a_ext = (MDUOp == OP_MULT) ? {{WIDTH{A[WIDTH-1]}}, A} : {{WIDTH{1'b0}}, A};
    assign w_b_ext = (MDUOp == OP_MULT) ? {{WIDTH{B[WIDTH-1]}}, B} : {{WIDTH{1'b0}}, B};
    assign w_prod  = w_a_ext * w_b_ext;

    // ------------------------------------------------------------------
    // Divide: sign-magnitude around a single unsigned divider.
    // MIN / -1 falls out naturally: |MIN| = 2^(W-1), negated back to MIN,
    // remainder 0.
    // ------------------------------------------------------------------
    logic             w_div_signed;
    logic             w_a_neg;
    logic             w_b_neg;
    logic             w_div_by_zero;
    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;
    logic [WIDTH-1:0] w_b_div;
    logic [WIDTH-1:0] w_quo_mag;
    logic [WIDTH-1:0] w_rem_mag;
    logic [WIDTH-1:0] w_quo;
    logic [WIDTH-1:0] w_rem;

    assign w_div_signed  = (MDUOp == OP_DIV);
    assign w_a_neg       = w_div_signed && A[WIDTH-1];
    assign w_b_neg       = w_div_signed && B[WIDTH-1];
    assign w_a_mag       = w_a_neg ? -A : A;
    assign w_b_mag       = w_b_neg ? -B : B;
    assign w_div_by_zero = (B == '0);
    // Divisor forced to 1 on B=0 only to keep the divider well defined;
    // the result is discarded via r_pend_wr.
    assign w_b_div       = w_div_by_zero ? WIDTH'(1) : w_b_mag;
    assign w_quo_mag     = w_a_mag / w_b_div;
    assign w_rem_mag     = w_a_mag % w_b_div;
    assign w_quo         = (w_a_neg ^ w_b_neg) ? -w_quo_mag : w_quo_mag;
    assign w_rem         = w_a_neg ? -w_rem_mag : w_rem_mag;

    logic [WIDTH-1:0] w_hi_res;
    logic [WIDTH-1:0] w_lo_res;

    assign w_hi_res = w_is_mul ? w_prod[2*WIDTH-1:WIDTH] : w_rem;
    assign w_lo_res = w_is_mul ? w_prod[WIDTH-1:0]       : w_quo;

    // ------------------------------------------------------------------
    // Sequencer and HI/LO
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_cnt     <= CNT_ZERO;
            r_hi      <= '0;
            r_lo      <= '0;
            r_hi_pend <= '0;
            r_lo_pend <= '0;
            r_pend_wr <= 1'b0;
        end else if (r_state == ST_IDLE) begin
            if (w_accept) begin
                r_hi_pend <= w_hi_res;
                r_lo_pend <= w_lo_res;
                r_pend_wr <= w_is_mul || !w_div_by_zero;
                r_cnt     <= w_is_mul ? CNT_MUL : CNT_DIV;
                r_state   <= ST_RUN;
            end
            if (w_mthi) begin
                r_hi <= A;
            end
            if (w_mtlo) begin
                r_lo <= A;
            end
        end else begin
            // RUN: commands on the inputs are ignored until completion.
            if (r_cnt == CNT_ONE) begin
                if (r_pend_wr) begin
                    r_hi <= r_hi_pend;
                    r_lo <= r_lo_pend;
                end
                r_cnt   <= CNT_ZERO;
                r_state <= ST_IDLE;
            end else begin
                r_cnt <= r_cnt - CNT_ONE;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign Busy = (r_state == ST_RUN);
    assign HI   = r_hi;
    assign LO   = r_lo;

    always_comb begin
        Out = '0;
        case (MDUOp)
            OP_MFHI: Out = r_hi;
            OP_MFLO: Out = r_lo;
            default: Out = '0;
        endcase
    end

endmodule

// File: doc/mdu_seq.md
# mdu_seq

Parametrised multiply/divide unit for the pipelined MIPS datapath, sitting in the E stage beside the ALU. It executes mult/multu/div/divu over a configurable number of cycles, owns the HI/LO registers, serves mfhi/mflo/mthi/mtlo, and exposes `Busy` so the hazard unit can stall D-stage MDU instructions. It extends the combinational decode/control scheme into a sequenced execution block with its own state.

## Interface
- `WIDTH`, 32: operand, HI and LO width.
- `MUL_CYCLES`, 5: busy cycles for mult/multu; legal range is 1 or more.
- `DIV_CYCLES`, 10: busy cycles for div/divu; legal range is 1 or more.
- `clk` input 1: single clock, rising edge.
- `reset` input 1: synchronous, active-high.
- `Start` input 1: E-stage instruction is a mult/multu/div/divu; qualified by `MDUOp`.
- `MDUOp` input 4: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo, 7 mthi, 8 mtlo; all other codes mean none.
- `Req` input 1: exception/interrupt flush this cycle; squashes any E-stage `Start` or mthi/mtlo.
- `A` input WIDTH: forwarded rs value.
- `B` input WIDTH: forwarded rt value.
- `Busy` output 1: operation in flight.
- `HI` output WIDTH: current HI register.
- `LO` output WIDTH: current LO register.
- `Out` output WIDTH: HI when `MDUOp`=mfhi, LO when `MDUOp`=mflo, else 0. Combinational.

## Operation
- States: IDLE, RUN. A counter holds the cycles remaining. Pending HI and LO results are held internally.
- IDLE with `Start`=1, `Req`=0 and `MDUOp` in 1..4:
  - Capture the result, computed from `A` and `B` at that edge.
  - Load the counter with MUL_CYCLES or DIV_CYCLES.
  - Go to RUN.
- In RUN, the counter decrements every cycle. When the counter reaches 1, the next edge:
  - writes the pending HI and LO;
  - clears the counter;
  - returns to IDLE.
- Arithmetic:
  - mult: signed 2·WIDTH-bit product; HI gets the upper half, LO the lower half.
  - multu: same, with unsigned operands.
  - div: LO = quotient truncated toward zero, HI = remainder carrying the sign of the dividend.
  - divu: unsigned quotient and remainder.
  - div of MIN by -1: LO = MIN, HI = 0.
- Divide by zero (B=0) for div/divu:
  - The unit still occupies RUN for DIV_CYCLES.
  - HI and LO are left unchanged at completion.
- mthi/mtlo, accepted only in IDLE with `Req`=0:
  - HI (or LO) takes `A` at the edge.
  - No busy period.
- Ignored commands:
  - `Start` or mthi/mtlo while in RUN is ignored. The hazard unit must stall these; they must never corrupt the op in flight.
  - `Req`=1 blocks acceptance of a new op.
  - `Req` does NOT cancel an op already in RUN; that op completes normally.
- mfhi/mflo are purely combinational reads of the registers. They return the stale pre-op value if issued during RUN, which is why the hazard unit must stall them.

## Timing
- Reset, in the cycle `reset` is sampled high: HI=0, LO=0, `Busy`=0, state IDLE, counter 0, pending results 0. This holds even mid-RUN; the op in flight is discarded.
- `Start` accepted at edge t (end of cycle t):
  - `Busy` is 1 during cycles t+1 … t+N, where N is MUL_CYCLES or DIV_CYCLES.
  - HI/LO update at the end of cycle t+N.
  - New values are visible on `HI`/`LO`/`Out` in cycle t+N+1, with `Busy`=0.
- A new `Start` is accepted in cycle t+N+1, giving back-to-back throughput of one op per N+1 cycles.
- `Busy` is a registered output with no combinational path from `Start`. The hazard unit stalls on (`Start` | `Busy`) when the D-stage instruction is an MDU instruction.
- mthi/mtlo at edge t: the new value is visible in cycle t+1.

## Test plan
- After reset, mult with A=0xFFFFFFFD (−3), B=5:
  - `Busy`=1 for exactly 5 cycles.
  - Then HI=0xFFFFFFFF, LO=0xFFFFFFF1.
  - `Out` with mflo reads 0xFFFFFFF1.
- multu with A=0xFFFFFFFF, B=2 gives HI=1, LO=0xFFFFFFFE.
- div with A=−7, B=2:
  - `Busy`=1 for 10 cycles.
  - LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- divu with A=0x10, B=0, starting from HI=0x11, LO=0x22 (set via mthi/mtlo):
  - `Busy` for 10 cycles.
  - HI=0x11, LO=0x22 afterwards.
- During RUN of mult 3×4:
  - Assert `Start` with div 100/7, and separately mtlo A=0x55.
  - Both are ignored; final HI=0, LO=12, `Busy` drops after 5 cycles.
- Flush and reset:
  - `Start`+mult with `Req`=1: `Busy` stays 0 and HI/LO are unchanged.
  - `reset` pulsed in the third RUN cycle of a multu: HI=LO=0 and `Busy`=0 on the next cycle, with no later write-back.
  - Repeat the suite with `WIDTH`=16, MUL_CYCLES=1, DIV_CYCLES=3.
